// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and sizing helpers for the configuration-chain loader.
//   state_e       : loader FSM states
//   CHAIN_LEN_DEF : default number of flops in the downstream config chain
//   WORD_W_DEF    : default bitstream word width
//   ccff_nwords() : words per load, ceil(chain_len / word_w)
//   ccff_cnt_w()  : width of a counter holding 0..n
//   ccff_idx_w()  : width of a bit index into a word_w-bit word
// ---------------------------------------------------------------------------
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam int CHAIN_LEN_DEF = 1024;
  localparam int WORD_W_DEF    = 8;

  function automatic int ccff_nwords(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int ccff_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ccff_idx_w(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
// Holds one bitstream word and presents it MSB-first, one bit per shift.
//   prog_clk   : programming clock
//   pReset     : synchronous active-high reset
//   load_i     : capture data_i and point at bit WORD_W-1 (wins over shift_i)
//   shift_i    : step to the next lower bit
//   data_i     : word to capture
//   bit_o      : currently selected bit
//   last_bit_o : the selected bit is bit 0, the last of the word
// ---------------------------------------------------------------------------
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_bit_o
);

  localparam int                IDX_W   = ccff_idx_w(WORD_W);
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  bit_idx_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. The word register is
  // reset as well: it is a single register, not a memory array, and a known
  // value keeps ccff_head clean from the first cycle.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      word_q    <= '0;
      bit_idx_q <= '0;
    end else if (load_i) begin
      word_q    <= data_i;
      bit_idx_q <= IDX_TOP;
    end else if (shift_i) begin
      bit_idx_q <= bit_idx_q - IDX_W'(1);
    end
  end

  assign bit_o      = word_q[bit_idx_q];
  assign last_bit_o = (bit_idx_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Loads a configuration bitstream into a serial config-flop chain. Words
// arrive on a valid/ready stream, are shifted out MSB-first on ccff_head, and
// config_enable is raised only on cycles that carry a real bit, so the chain
// sees exactly CHAIN_LEN shifts per load whatever the upstream stalls.
//
// Ports
//   prog_clk      in  programming clock (only clock)
//   pReset        in  synchronous active-high reset
//   cfg_start     in  1-cycle pulse, starts a load from IDLE or DONE
//   s_data        in  bitstream word, bit WORD_W-1 shifted first
//   s_valid       in  s_data valid
//   s_ready       out word accepted this cycle when s_valid is high
//   ccff_head     out serial bit into the chain head
//   config_enable out chain shift enable
//   ccff_tail     in  chain tail, used only by the tail check
//   busy          out high in WAIT_WORD and SHIFT
//   done          out high in DONE
//   err           out sticky tail-check error
//
// Build option
//   CCFF_TAIL_CHECK_EN : when defined, the first load after pReset expects
//   the chain tail to read 0 on every shift and sets err otherwise. When
//   undefined, err is tied 0 and ccff_tail is ignored.
// ---------------------------------------------------------------------------
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int NWORDS = ccff_nwords(CHAIN_LEN, WORD_W);
  localparam int CNT_W  = ccff_cnt_w(CHAIN_LEN);
  localparam int WCNT_W = ccff_cnt_w(NWORDS);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CHAIN_LEN);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(NWORDS);

  state_e            state_q;
  logic [CNT_W-1:0]  remaining_q;   // chain bits still to shift this load
  logic [WCNT_W-1:0] words_left_q;  // words still to accept this load

  logic in_shift;
  logic last_chain_bit;
  logic accept;
  logic start_load;
  logic ser_bit;
  logic ser_last_bit;

  assign in_shift       = (state_q == SHIFT);
  assign last_chain_bit = in_shift && (remaining_q == CNT_W'(1));
  assign start_load     = cfg_start && ((state_q == IDLE) || (state_q == DONE));

  // In SHIFT a new word is only taken on the last bit of the current word and
  // only if the chain still needs more bits; this gives gap-free streaming
  // while never over-reading the bitstream.
  assign s_ready = (words_left_q != '0) &&
                   ((state_q == WAIT_WORD) ||
                    (in_shift && ser_last_bit && (remaining_q > CNT_W'(1))));
  assign accept  = s_valid && s_ready;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      words_left_q <= '0;
    end else begin
      if (start_load) begin
        remaining_q  <= CNT_LOAD;
        words_left_q <= WCNT_LOAD;
      end else begin
        if (in_shift) remaining_q  <= remaining_q - CNT_W'(1);
        if (accept)   words_left_q <= words_left_q - WCNT_W'(1);
      end

      unique case (state_q)
        IDLE, DONE: if (cfg_start) state_q <= WAIT_WORD;
        WAIT_WORD:  if (accept)    state_q <= SHIFT;
        SHIFT: begin
          // The final chain bit ends the load even mid-word; leftover low
          // bits of that word are simply never shifted.
          if (last_chain_bit)                 state_q <= DONE;
          else if (ser_last_bit && !accept)   state_q <= WAIT_WORD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .load_i     (accept),
    .shift_i    (in_shift),
    .data_i     (s_data),
    .bit_o      (ser_bit),
    .last_bit_o (ser_last_bit)
  );

  // All outputs decode straight from flops, so none depends on an input.
  assign config_enable = in_shift;
  assign ccff_head     = in_shift && ser_bit;
  assign busy          = (state_q == WAIT_WORD) || in_shift;
  assign done          = (state_q == DONE);

`ifdef CCFF_TAIL_CHECK_EN
  // chain_clean marks that the chain should still hold its post-reset zeros,
  // which is only true until the first load completes.
  logic chain_clean_q;
  logic err_q;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_clean_q <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      if (in_shift && chain_clean_q && ccff_tail) err_q <= 1'b1;
      if (last_chain_bit)                         chain_clean_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
// Directed bench for ccff_chain_loader. Instance A: CHAIN_LEN=16, WORD_W=8.
// Instance B: CHAIN_LEN=10, WORD_W=8. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       a_start, a_valid, a_ready, a_head, a_en, a_tail, a_busy, a_done, a_err;
  logic [7:0] a_data;
  logic       b_start, b_valid, b_ready, b_head, b_en, b_tail, b_busy, b_done, b_err;
  logic [7:0] b_data;

  int checks = 0;
  int errors = 0;

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_a (
    .prog_clk      (clk),
    .pReset        (rst),
    .cfg_start     (a_start),
    .s_data        (a_data),
    .s_valid       (a_valid),
    .s_ready       (a_ready),
    .ccff_head     (a_head),
    .config_enable (a_en),
    .ccff_tail     (a_tail),
    .busy          (a_busy),
    .done          (a_done),
    .err           (a_err)
  );

  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_b (
    .prog_clk      (clk),
    .pReset        (rst),
    .cfg_start     (b_start),
    .s_data        (b_data),
    .s_valid       (b_valid),
    .s_ready       (b_ready),
    .ccff_head     (b_head),
    .config_enable (b_en),
    .ccff_tail     (b_tail),
    .busy          (b_busy),
    .done          (b_done),
    .err           (b_err)
  );

  // Drives one two-word load on instance A (sel=0) or B (sel=1) and records
  // what the chain saw. gap: cycles s_valid is withheld once word 1 could be
  // taken. mid_start: pulse cfg_start on that enable cycle (-1 = never).
  // tail_at: 0 = tail high throughout, k>0 = tail high on shift k, -1 = never.
  task automatic run_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                          input int gap, input int mid_start, input int tail_at,
                          output logic [31:0] heads, output int n_en, output int holes,
                          output int lat, output bit to);
    int   widx, gap_left, cyc, acc_cyc;
    bit   seen;
    logic rdy, en, hd, dn;
    heads = '0; n_en = 0; holes = 0; lat = -1; to = 1'b1;
    widx = 0; gap_left = gap; cyc = 0; acc_cyc = -1; seen = 1'b0;
    @(negedge clk);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      rdy = sel ? b_ready : a_ready;
      en  = sel ? b_en    : a_en;
      hd  = sel ? b_head  : a_head;
      dn  = sel ? b_done  : a_done;
      if (dn) begin
        lat = cyc - acc_cyc;
        to  = 1'b0;
        break;
      end
      if (en) begin
        heads = {heads[30:0], hd};
        n_en++;
        seen = 1'b1;
      end else if (seen) begin
        holes++;
      end
      if (en && n_en == mid_start) begin
        if (sel) b_start = 1'b1; else a_start = 1'b1;
      end
      if (!sel) a_tail = (tail_at == 0) || (en && n_en == tail_at);
      if (widx < 2) begin
        if (widx > 0 && gap_left > 0 && rdy) begin
          if (sel) b_valid = 1'b0; else a_valid = 1'b0;
          gap_left--;
        end else begin
          if (sel) begin b_valid = 1'b1; b_data = (widx == 0) ? w0 : w1; end
          else     begin a_valid = 1'b1; a_data = (widx == 0) ? w0 : w1; end
          if (rdy) begin
            if (widx == 0) acc_cyc = cyc;
            widx++;
          end
        end
      end else begin
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
      end
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0; a_tail = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    a_start = 0; a_valid = 0; a_data = '0; a_tail = 0;
    b_start = 0; b_valid = 0; b_data = '0; b_tail = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, a_head, a_en, a_busy, a_done, a_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a got %b want 000000", {a_ready, a_head, a_en, a_busy, a_done, a_err});
    end
    checks++;
    if ({b_ready, b_head, b_en, b_busy, b_done, b_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_b got %b want 000000", {b_ready, b_head, b_en, b_busy, b_done, b_err});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_ready} !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold got %b want 000", {a_busy, a_done, a_ready});
    end
  endtask

  task automatic test_basic_load();
    logic [31:0] heads; int n_en, holes, lat; bit to;
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -1, heads, n_en, holes, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++;
    if (heads !== 32'h0000A53C) begin errors++; $display("FAIL basic_heads got %h want 0000a53c", heads); end
    checks++;
    if (n_en !== 16 || holes !== 0) begin
      errors++; $display("FAIL basic_enables got %0d/%0d holes want 16/0", n_en, holes);
    end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
    checks++;
    if ({a_done, a_busy, a_ready, a_en} !== 4'b1000) begin
      errors++; $display("FAIL basic_done_state got %b want 1000", {a_done, a_busy, a_ready, a_en});
    end
  endtask

  task automatic test_stall_gap();
    logic [31:0] heads; int n_en, holes, lat; bit to;
    run_load(1'b0, 8'hA5, 8'h3C, 3, -1, -1, heads, n_en, holes, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL gap_timeout got no done want done"); end
    checks++;
    if (heads !== 32'h0000A53C) begin errors++; $display("FAIL gap_heads got %h want 0000a53c", heads); end
    checks++;
    if (n_en !== 16) begin errors++; $display("FAIL gap_enables got %0d want 16", n_en); end
    checks++;
    if (holes !== 3) begin errors++; $display("FAIL gap_holes got %0d want 3", holes); end
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL gap_latency got %0d want 20", lat); end
  endtask

  task automatic test_short_chain();
    logic [31:0] heads; int n_en, holes, lat; bit to;
    run_load(1'b1, 8'hFF, 8'hC0, 0, -1, -1, heads, n_en, holes, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL short_timeout got no done want done"); end
    checks++;
    if (heads !== 32'h000003FF) begin errors++; $display("FAIL short_heads got %h want 000003ff", heads); end
    checks++;
    if (n_en !== 10 || holes !== 0) begin
      errors++; $display("FAIL short_enables got %0d/%0d holes want 10/0", n_en, holes);
    end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL short_latency got %0d want 11", lat); end
    checks++;
    if ({b_done, b_ready, b_en} !== 3'b100) begin
      errors++; $display("FAIL short_done_state got %b want 100", {b_done, b_ready, b_en});
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] heads; int n_en, holes, lat; bit to;
    int  n;
    bit  hit;
    n = 0; hit = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      a_start = 1'b0; a_valid = 1'b1; a_data = 8'hA5;
      if (a_en) n++;
      if (n == 5) begin
        rst = 1'b1; a_valid = 1'b0; hit = 1'b1;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach got %0d shifts want 5", n); end
    checks++;
    if ({a_ready, a_head, a_en, a_busy, a_done, a_err} !== 6'b0) begin
      errors++;
      $display("FAIL abort_outputs got %b want 000000", {a_ready, a_head, a_en, a_busy, a_done, a_err});
    end
    rst = 1'b0;
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -1, heads, n_en, holes, lat, to);
    checks++;
    if (to || heads !== 32'h0000A53C || n_en !== 16 || lat !== 17) begin
      errors++;
      $display("FAIL abort_restart got heads=%h en=%0d lat=%0d to=%0d want a53c/16/17/0",
               heads, n_en, lat, to);
    end
  endtask

  task automatic test_start_ignored_and_restart();
    logic [31:0] heads; int n_en, holes, lat; bit to;
    run_load(1'b0, 8'hA5, 8'h3C, 0, 4, -1, heads, n_en, holes, lat, to);
    checks++;
    if (to || heads !== 32'h0000A53C || n_en !== 16 || holes !== 0 || lat !== 17) begin
      errors++;
      $display("FAIL busy_start got heads=%h en=%0d holes=%0d lat=%0d want a53c/16/0/17",
               heads, n_en, holes, lat);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({a_done, a_busy} !== 2'b10) begin
      errors++; $display("FAIL done_hold got %b want 10", {a_done, a_busy});
    end
    run_load(1'b0, 8'h5A, 8'hC3, 0, -1, -1, heads, n_en, holes, lat, to);
    checks++;
    if (to || heads !== 32'h00005AC3 || n_en !== 16 || lat !== 17) begin
      errors++;
      $display("FAIL done_restart got heads=%h en=%0d lat=%0d want 5ac3/16/17", heads, n_en, lat);
    end
  endtask

  task automatic test_tail_check();
    logic [31:0] heads; int n_en, holes, lat; bit to;
    apply_reset();
`ifdef CCFF_TAIL_CHECK_EN
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, 3, heads, n_en, holes, lat, to);
    checks++;
    if (to || a_err !== 1'b1) begin errors++; $display("FAIL tail_set got err=%b want 1", a_err); end
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, 0, heads, n_en, holes, lat, to);
    checks++;
    if (to || a_err !== 1'b1) begin errors++; $display("FAIL tail_sticky got err=%b want 1", a_err); end
    apply_reset();
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL tail_reset got err=%b want 0", a_err); end
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, -1, heads, n_en, holes, lat, to);
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, 0, heads, n_en, holes, lat, to);
    checks++;
    if (to || a_err !== 1'b0) begin errors++; $display("FAIL tail_inactive got err=%b want 0", a_err); end
`else
    run_load(1'b0, 8'hA5, 8'h3C, 0, -1, 0, heads, n_en, holes, lat, to);
    checks++;
    if (to || a_err !== 1'b0) begin errors++; $display("FAIL tail_disabled got err=%b want 0", a_err); end
`endif
    checks++;
    if (heads !== 32'h0000A53C) begin errors++; $display("FAIL tail_heads got %h want 0000a53c", heads); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_stall_gap();
    test_short_chain();
    test_reset_mid_load();
    test_start_ignored_and_restart();
    test_tail_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
